// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score timer: FSM states and BCD digit geometry.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAUSED,
    ST_OVER
  } state_t;

  localparam int unsigned    BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int unsigned    DIGITS  = 4;

endpackage

// File: rtl/score_keeper_if.sv
// Control inputs and display/score outputs of the score timer, bundled for the display path.
interface score_keeper_if;
  import score_keeper_pkg::*;

  logic                      pause;
  logic                      gameover;
  logic                      start;
  logic [BCD_W-1:0]          val1;
  logic [BCD_W-1:0]          val2;
  logic [BCD_W-1:0]          val3;
  logic [BCD_W-1:0]          val4;
  logic [DIGITS*BCD_W-1:0]   hi_score;
  logic                      new_high;
  logic                      running;

  modport master (
    output pause, gameover, start,
    input  val1, val2, val3, val4, hi_score, new_high, running
  );

  modport slave (
    input  pause, gameover, start,
    output val1, val2, val3, val4, hi_score, new_high, running
  );

endinterface

// File: rtl/score_keeper_bcd_digit.sv
// One BCD decade: increments on inc_in, wraps 9->0 and raises carry_out in that cycle.
module bcd_digit
  import score_keeper_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_in,
  output logic [BCD_W-1:0] val,
  output logic             carry_out
);

  logic [BCD_W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (inc_in) begin
      val_d = (val_q == BCD_MAX) ? '0 : val_q + BCD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val       = val_q;
  assign carry_out = inc_in & (val_q == BCD_MAX);

endmodule

// File: rtl/score_keeper.sv
// Game score timer: clock-enabled 4-digit BCD seconds counter with pause, game-over freeze and high score.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic         clk_100mhz,
  input  logic         rst,
  score_keeper_if.slave bus
);

  localparam int unsigned      PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);

  state_t                    state_q, state_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic [DIGITS*BCD_W-1:0]   hi_q, hi_d;
  logic                      new_high_q, new_high_d;
  logic                      running_q, running_d;

  logic                      clr, inc, sat, enter_over;
  logic [BCD_W-1:0]          dig [DIGITS];
  logic [DIGITS:0]           carry;
  logic [DIGITS*BCD_W-1:0]   score;
  logic                      top_carry_unused;

  assign carry[0]         = inc;
  assign top_carry_unused = carry[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk_100mhz),
      .rst       (rst),
      .clr       (clr),
      .inc_in    (carry[i]),
      .val       (dig[i]),
      .carry_out (carry[i+1])
    );
  end

  assign score = {dig[3], dig[2], dig[1], dig[0]};

  always_comb begin
    sat = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      sat = sat & (dig[i] == BCD_MAX);
    end
  end

  // Priority inside each state: gameover > start > pause > tick.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    hi_d       = hi_q;
    new_high_d = new_high_q;
    clr        = 1'b0;
    inc        = 1'b0;
    enter_over = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.gameover) begin
          enter_over = 1'b1;
        end else if (bus.start) begin
          clr     = 1'b1;
          presc_d = '0;
        end else if (bus.pause) begin
          state_d = ST_PAUSED;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          inc     = ~sat;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSED: begin
        if (bus.gameover) begin
          enter_over = 1'b1;
        end else if (bus.start) begin
          clr     = 1'b1;
          presc_d = '0;
          state_d = ST_RUN;
        end else if (!bus.pause) begin
          state_d = ST_RUN;
        end
      end
      ST_OVER: begin
        if (bus.start) begin
          clr        = 1'b1;
          presc_d    = '0;
          new_high_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // BCD digits order like binary, so a plain unsigned compare ranks scores.
    if (enter_over) begin
      state_d    = ST_OVER;
      new_high_d = 1'b0;
      if (score > hi_q) begin
        hi_d       = score;
        new_high_d = 1'b1;
      end
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      presc_q    <= '0;
      hi_q       <= '0;
      new_high_q <= 1'b0;
      running_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      hi_q       <= hi_d;
      new_high_q <= new_high_d;
      running_q  <= running_d;
    end
  end

  assign bus.val1     = dig[0];
  assign bus.val2     = dig[1];
  assign bus.val3     = dig[2];
  assign bus.val4     = dig[3];
  assign bus.hi_score = hi_q;
  assign bus.new_high = new_high_q;
  assign bus.running  = running_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper at TICK_DIV=4: table of scenario rows, long carry/saturation run, random soak vs. integer model.
module tb_score_keeper;

  localparam int DIV = 4;
  localparam int M_RUN = 0, M_PAUSED = 1, M_OVER = 2;

  logic clk = 1'b0;
  logic rst;

  score_keeper_if bus();

  score_keeper #(.TICK_DIV(DIV)) dut (
    .clk_100mhz (clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers for score/high score, mode and elapsed sub-second count.
  int m_mode, m_presc, m_score, m_hi;
  bit m_nh;

  typedef struct {
    bit p; bit g; bit s;
    int unsigned n;
    int score; int hi; bit nh; bit run;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit p, bit g, bit s, int unsigned n, int score, int hi, bit nh, bit run);
    vec_t v;
    v = '{p: p, g: g, s: s, n: n, score: score, hi: hi, nh: nh, run: run};
    tbl.push_back(v);
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic void model_reset();
    m_mode = M_RUN; m_presc = 0; m_score = 0; m_hi = 0; m_nh = 1'b0;
  endfunction

  function automatic void model_clock(bit p, bit g, bit s);
    if (m_mode == M_OVER) begin
      if (s) begin
        m_score = 0; m_presc = 0; m_nh = 1'b0; m_mode = M_RUN;
      end
    end else if (g) begin
      m_nh = 1'b0;
      if (m_score > m_hi) begin
        m_hi = m_score; m_nh = 1'b1;
      end
      m_mode = M_OVER;
    end else if (s) begin
      m_score = 0; m_presc = 0; m_mode = M_RUN;
    end else if (m_mode == M_PAUSED) begin
      if (!p) m_mode = M_RUN;
    end else if (p) begin
      m_mode = M_PAUSED;
    end else if (m_presc == DIV - 1) begin
      m_presc = 0;
      if (m_score < 9999) m_score = m_score + 1;
    end else begin
      m_presc = m_presc + 1;
    end
  endfunction

  task automatic check(string name, int score, int hi, bit nh, bit run);
    logic [33:0] got, exp;
    got = {bus.val4, bus.val3, bus.val2, bus.val1, bus.hi_score, bus.new_high, bus.running};
    exp = {to_bcd(score), to_bcd(hi), nh, run};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got score=%h hi=%h new_high=%b running=%b, expected score=%h hi=%h new_high=%b running=%b",
               name, $time, got[33:18], got[17:2], got[1], got[0], exp[33:18], exp[17:2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_clock(bus.pause, bus.gameover, bus.start);
    #1;
    check("cycle", m_score, m_hi, m_nh, m_mode == M_RUN);
  endtask

  task automatic drive(bit p, bit g, bit s);
    bus.pause = p; bus.gameover = g; bus.start = s;
  endtask

  task automatic run(bit p, bit g, bit s, int unsigned n);
    drive(p, g, s);
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0);
    model_reset();
    #1;
    check("reset", 0, 0, 0, 1);
    step();
    rst = 1'b0;

    add(0,0,0,40, 10, 0,0,1);
    add(0,0,0, 8, 12, 0,0,1);
    add(0,1,0, 1, 12,12,1,0);
    add(0,0,0,10, 12,12,1,0);
    add(0,0,1, 1,  0,12,0,1);
    add(0,0,0,20,  5,12,0,1);
    add(0,1,0, 1,  5,12,0,0);
    add(0,0,1, 1,  0,12,0,1);
    add(0,0,0,48, 12,12,0,1);
    add(0,1,0, 1, 12,12,0,0);
    add(0,0,1, 1,  0,12,0,1);
    add(0,0,0,52, 13,12,0,1);
    add(0,1,0, 1, 13,13,1,0);
    add(0,0,1, 1,  0,13,0,1);
    add(0,1,1, 1,  0,13,0,0);
    add(0,0,1, 1,  0,13,0,1);
    add(0,0,0,12,  3,13,0,1);
    add(1,0,0,20,  3,13,0,0);
    add(0,0,0, 1,  3,13,0,1);
    add(0,0,0, 4,  4,13,0,1);
    add(0,0,0, 3,  4,13,0,1);
    add(1,0,0, 1,  4,13,0,0);
    add(0,0,0, 1,  4,13,0,1);
    add(0,0,0, 1,  5,13,0,1);
    add(0,0,0, 8,  7,13,0,1);
    add(0,0,0, 3,  7,13,0,1);
    add(0,1,0, 1,  7,13,0,0);
    add(0,0,0, 5,  7,13,0,0);
    add(0,0,1, 1,  0,13,0,1);
    add(0,0,0,56, 14,13,0,1);
    add(0,1,0,50, 14,14,1,0);
    add(0,0,1, 1,  0,14,0,1);

    foreach (tbl[i]) begin
      run(tbl[i].p, tbl[i].g, tbl[i].s, tbl[i].n);
      check($sformatf("row%0d", i), tbl[i].score, tbl[i].hi, tbl[i].nh, tbl[i].run);
    end

    run(0, 0, 0, DIV * 99);   check("to_0099", 99, 14, 0, 1);
    run(0, 0, 0, DIV);        check("to_0100", 100, 14, 0, 1);
    run(0, 0, 0, DIV * 899);  check("to_0999", 999, 14, 0, 1);
    run(0, 0, 0, DIV);        check("to_1000", 1000, 14, 0, 1);
    run(0, 0, 0, DIV * 8999); check("to_9999", 9999, 14, 0, 1);
    run(0, 0, 0, DIV * 8);    check("sat_hold", 9999, 14, 0, 1);
    run(0, 1, 0, 1);          check("commit_9999", 9999, 9999, 1, 0);
    run(0, 0, 1, 1);          check("restart", 0, 9999, 0, 1);
    run(0, 0, 0, 6);          check("pre_rst", 1, 9999, 0, 1);

    drive(0, 0, 0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst", 0, 0, 0, 1);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 2, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
